// File: rtl/protein_tarama_kontrol.sv
// ============================================================================
// Module      : protein_tarama_kontrol
// Description : Codon-pair scan sequencer; delimits proteins from scorer match
//               bits and reports the best complete protein and the count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module protein_tarama_kontrol #(
    parameter int ADR_W       = 10,
    parameter int MAX_UZUNLUK = 1000,
    parameter int PUAN_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              basla,
    input  logic [ADR_W:0]    dizi_uzunluk,
    output logic              mem_oku,
    output logic [ADR_W-1:0]  mem_adr,
    input  logic [5:0]        mem_kodon1,
    input  logic [5:0]        mem_kodon2,
    output logic [5:0]        kodon1_o,
    output logic [5:0]        kodon2_o,
    output logic              kodon_gecerli,
    input  logic              eslesme,
    output logic [PUAN_W-1:0] en_iyi_puan,
    output logic [9:0]        en_iyi_uzunluk,
    output logic [7:0]        protein_sayisi,
    output logic              mesgul,
    output logic              bitti
);

    typedef enum logic [1:0] {
        BOS    = 2'd0,
        OKU    = 2'd1,
        BOSALT = 2'd2,
        BITTI  = 2'd3
    } durum_t;

    localparam logic [5:0]     START_KODON = 6'b000110;
    localparam logic [9:0]     MAX_U       = 10'(MAX_UZUNLUK);
    localparam logic [ADR_W:0] N_MAX       = {1'b1, {ADR_W{1'b0}}};

    durum_t              durum_q, durum_d;
    logic [ADR_W:0]      n_q, n_d;
    logic [ADR_W-1:0]    adr_q, adr_d;
    logic                oku_q, oku_d;
    logic                gec_q, gec_d;
    logic                tuket_q, tuket_d;
    logic [5:0]          kod_q, kod_d;
    logic                aktif_q, aktif_d;
    logic [9:0]          uzunluk_q, uzunluk_d;
    logic [PUAN_W-1:0]   puan_q, puan_d;
    logic [PUAN_W-1:0]   en_iyi_puan_q, en_iyi_puan_d;
    logic [9:0]          en_iyi_uz_q, en_iyi_uz_d;
    logic [7:0]          sayi_q, sayi_d;
    logic                mesgul_q, mesgul_d;
    logic                bitti_q, bitti_d;
    logic                dur_kodon;
    logic [PUAN_W-1:0]   esl_genis;

    assign dur_kodon = (kod_q == 6'b011000) || (kod_q == 6'b010000) || (kod_q == 6'b010010);
    assign esl_genis = {{(PUAN_W-1){1'b0}}, eslesme};

    always_comb begin
        durum_d       = durum_q;
        n_d           = n_q;
        adr_d         = adr_q;
        oku_d         = oku_q;
        gec_d         = oku_q;
        tuket_d       = gec_q;
        kod_d         = mem_kodon1;
        aktif_d       = aktif_q;
        uzunluk_d     = uzunluk_q;
        puan_d        = puan_q;
        en_iyi_puan_d = en_iyi_puan_q;
        en_iyi_uz_d   = en_iyi_uz_q;
        sayi_d        = sayi_q;

        case (durum_q)
            BOS: begin
                if (basla) begin
                    en_iyi_puan_d = '0;
                    en_iyi_uz_d   = '0;
                    sayi_d        = '0;
                    aktif_d       = 1'b0;
                    uzunluk_d     = '0;
                    puan_d        = '0;
                    if (dizi_uzunluk == '0) begin
                        durum_d = BITTI;
                    end else begin
                        n_d     = (dizi_uzunluk > N_MAX) ? N_MAX : dizi_uzunluk;
                        adr_d   = '0;
                        oku_d   = 1'b1;
                        durum_d = OKU;
                    end
                end
            end
            OKU: begin
                if ({1'b0, adr_q} == n_q - 1'b1) begin
                    oku_d   = 1'b0;
                    durum_d = BOSALT;
                end else begin
                    adr_d = adr_q + 1'b1;
                end
            end
            BOSALT: begin
                // Once the scorer stage is empty, this cycle consumes the last index.
                if (!gec_q) durum_d = BITTI;
            end
            default: durum_d = BOS;
        endcase

        if (tuket_q) begin
            if (!aktif_q) begin
                if (kod_q == START_KODON) begin
                    aktif_d   = 1'b1;
                    uzunluk_d = 10'd1;
                    puan_d    = esl_genis;
                end
            end else if (dur_kodon) begin
                if (sayi_q != 8'hFF) sayi_d = sayi_q + 8'd1;
                if (puan_q > en_iyi_puan_q) begin
                    en_iyi_puan_d = puan_q;
                    en_iyi_uz_d   = uzunluk_q;
                end
                aktif_d = 1'b0;
            end else if (uzunluk_q == MAX_U) begin
                aktif_d = 1'b0;
            end else begin
                uzunluk_d = uzunluk_q + 10'd1;
                puan_d    = puan_q + esl_genis;
            end
        end

        mesgul_d = (durum_d == OKU) || (durum_d == BOSALT);
        bitti_d  = (durum_d == BITTI);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum_q       <= BOS;
            n_q           <= '0;
            adr_q         <= '0;
            oku_q         <= 1'b0;
            gec_q         <= 1'b0;
            tuket_q       <= 1'b0;
            kod_q         <= '0;
            aktif_q       <= 1'b0;
            uzunluk_q     <= '0;
            puan_q        <= '0;
            en_iyi_puan_q <= '0;
            en_iyi_uz_q   <= '0;
            sayi_q        <= '0;
            mesgul_q      <= 1'b0;
            bitti_q       <= 1'b0;
        end else begin
            durum_q       <= durum_d;
            n_q           <= n_d;
            adr_q         <= adr_d;
            oku_q         <= oku_d;
            gec_q         <= gec_d;
            tuket_q       <= tuket_d;
            kod_q         <= kod_d;
            aktif_q       <= aktif_d;
            uzunluk_q     <= uzunluk_d;
            puan_q        <= puan_d;
            en_iyi_puan_q <= en_iyi_puan_d;
            en_iyi_uz_q   <= en_iyi_uz_d;
            sayi_q        <= sayi_d;
            mesgul_q      <= mesgul_d;
            bitti_q       <= bitti_d;
        end
    end

    assign mem_oku        = oku_q;
    assign mem_adr        = adr_q;
    assign kodon1_o       = mem_kodon1;
    assign kodon2_o       = mem_kodon2;
    assign kodon_gecerli  = gec_q;
    assign en_iyi_puan    = en_iyi_puan_q;
    assign en_iyi_uzunluk = en_iyi_uz_q;
    assign protein_sayisi = sayi_q;
    assign mesgul         = mesgul_q;
    assign bitti          = bitti_q;

endmodule

`default_nettype wire

// File: tb/tb_protein_tarama_kontrol.sv
// ============================================================================
// Module      : tb_protein_tarama_kontrol
// Description : Self-checking bench with memory and scorer models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_protein_tarama_kontrol;

    localparam logic [5:0] START = 6'b000110;
    localparam logic [5:0] STOP1 = 6'b011000;
    localparam logic [5:0] STOP2 = 6'b010000;
    localparam logic [5:0] STOP3 = 6'b010010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        basla;
    logic [10:0] dizi_uzunluk;
    logic        mem_oku;
    logic [9:0]  mem_adr;
    logic [5:0]  mem_kodon1 = 6'd0;
    logic [5:0]  mem_kodon2 = 6'd0;
    logic [5:0]  kodon1_o, kodon2_o;
    logic        kodon_gecerli;
    logic        eslesme = 1'b0;
    logic [15:0] en_iyi_puan;
    logic [9:0]  en_iyi_uzunluk;
    logic [7:0]  protein_sayisi;
    logic        mesgul, bitti;

    protein_tarama_kontrol #(.ADR_W(10), .MAX_UZUNLUK(1000), .PUAN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .basla(basla), .dizi_uzunluk(dizi_uzunluk),
        .mem_oku(mem_oku), .mem_adr(mem_adr), .mem_kodon1(mem_kodon1), .mem_kodon2(mem_kodon2),
        .kodon1_o(kodon1_o), .kodon2_o(kodon2_o), .kodon_gecerli(kodon_gecerli), .eslesme(eslesme),
        .en_iyi_puan(en_iyi_puan), .en_iyi_uzunluk(en_iyi_uzunluk), .protein_sayisi(protein_sayisi),
        .mesgul(mesgul), .bitti(bitti)
    );

    always #5 clk = ~clk;

    logic [5:0] mem1 [1024];
    logic [5:0] mem2 [1024];
    bit         esl  [1024];

    int checks = 0;
    int failures = 0;
    int exp_puan, exp_uz, exp_sayi;
    int obs_bitti, obs_oku, obs_tim, obs_pres_err, obs_pres_cnt;
    bit obs_after;
    int sc_idx = 0;
    int pres_err = 0;

    // Synchronous sequence memory: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_oku) begin
            mem_kodon1 <= mem1[mem_adr];
            mem_kodon2 <= mem2[mem_adr];
        end
    end

    // Scorer: returns the planned match bit for each presented pair, junk otherwise.
    always @(posedge clk) begin
        if (kodon_gecerli && sc_idx < 1024) begin
            eslesme <= esl[sc_idx];
            if (kodon1_o !== mem1[sc_idx] || kodon2_o !== mem2[sc_idx]) pres_err <= pres_err + 1;
            sc_idx <= sc_idx + 1;
        end else begin
            eslesme <= 1'($urandom);
            if (!mesgul) begin
                sc_idx   <= 0;
                pres_err <= 0;
            end
        end
    end

    function automatic void model(input int n);
        int nn, len, sc;
        bit ak;
        nn = (n > 1024) ? 1024 : n;
        exp_puan = 0; exp_uz = 0; exp_sayi = 0;
        ak = 0; len = 0; sc = 0;
        for (int i = 0; i < nn; i++) begin
            if (!ak) begin
                if (mem1[i] == START) begin ak = 1; len = 1; sc = int'(esl[i]); end
            end else if (mem1[i] == STOP1 || mem1[i] == STOP2 || mem1[i] == STOP3) begin
                if (exp_sayi < 255) exp_sayi++;
                if (sc > exp_puan) begin exp_puan = sc; exp_uz = len; end
                ak = 0;
            end else if (len == 1000) begin
                ak = 0;
            end else begin
                len++; sc += int'(esl[i]);
            end
        end
    endfunction

    task automatic fill_plain();
        for (int i = 0; i < 1024; i++) begin
            mem1[i] = 6'd1; mem2[i] = 6'($urandom); esl[i] = 1'($urandom);
        end
    endtask

    task automatic fill_random();
        int r;
        for (int i = 0; i < 1024; i++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1:    mem1[i] = START;
                2:       mem1[i] = STOP1;
                3:       mem1[i] = ($urandom_range(0, 1) == 0) ? STOP2 : STOP3;
                default: mem1[i] = 6'($urandom);
            endcase
            mem2[i] = 6'($urandom); esl[i] = 1'($urandom);
        end
    endtask

    // Drives one scan and records what was observed, cycle by cycle.
    task automatic run_scan(input int n, input bit poke);
        int nn;
        nn = (n > 1024) ? 1024 : n;
        obs_bitti = -1; obs_oku = 0; obs_tim = 0;
        @(negedge clk);
        basla = 1'b1; dizi_uzunluk = 11'(n);
        for (int c = 1; c <= nn + 10; c++) begin
            @(negedge clk);
            basla = (poke && c == 3);
            if (poke && c == 3) dizi_uzunluk = 11'd5;
            if (mem_oku) begin
                obs_oku++;
                if (mem_adr !== 10'(c - 1) || c > nn) obs_tim++;
            end else if (c <= nn) obs_tim++;
            if (kodon_gecerli !== (c >= 2 && c <= nn + 1)) obs_tim++;
            if (mesgul !== (nn >= 1 && c <= nn + 2)) obs_tim++;
            if (bitti === 1'b1) begin
                obs_bitti = c; obs_pres_err = pres_err; obs_pres_cnt = sc_idx;
                break;
            end
        end
        basla = 1'b0;
        @(negedge clk);
        obs_after = bitti;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; basla = 1'b0; dizi_uzunluk = '0;
        repeat (3) @(negedge clk);
        checks++; if (mem_oku !== 1'b0 || mesgul !== 1'b0 || bitti !== 1'b0) begin failures++;
            $display("FAIL reset_ctrl got oku=%b mesgul=%b bitti=%b exp 0 0 0", mem_oku, mesgul, bitti); end
        checks++; if (en_iyi_puan !== 16'd0 || en_iyi_uzunluk !== 10'd0 || protein_sayisi !== 8'd0) begin failures++;
            $display("FAIL reset_results got %0d %0d %0d exp 0 0 0", en_iyi_puan, en_iyi_uzunluk, protein_sayisi); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_plain();
        mem1[0] = START; mem1[1] = 6'b000001; mem1[2] = 6'b000010; mem1[3] = STOP1; mem1[4] = 6'b000001;
        esl[0] = 1; esl[1] = 1; esl[2] = 0; esl[3] = 1; esl[4] = 1;
        run_scan(5, 0);
        checks++; if (obs_bitti != 8) begin failures++; $display("FAIL basic_bitti_cycle got=%0d exp=8", obs_bitti); end
        checks++; if (obs_tim != 0 || obs_oku != 5) begin failures++; $display("FAIL basic_timing errs=%0d reads=%0d exp 0 5", obs_tim, obs_oku); end
        checks++; if (obs_pres_err != 0 || obs_pres_cnt != 5) begin failures++; $display("FAIL basic_pairs errs=%0d cnt=%0d exp 0 5", obs_pres_err, obs_pres_cnt); end
        checks++; if (protein_sayisi !== 8'd1 || en_iyi_puan !== 16'd2 || en_iyi_uzunluk !== 10'd3) begin failures++;
            $display("FAIL basic_result got cnt=%0d puan=%0d uz=%0d exp 1 2 3", protein_sayisi, en_iyi_puan, en_iyi_uzunluk); end
        checks++; if (obs_after !== 1'b0) begin failures++; $display("FAIL basic_bitti_pulse got=%b exp=0", obs_after); end
    endtask

    task automatic test_two_proteins();
        fill_plain();
        mem1[0] = START; mem1[3] = STOP2; mem1[4] = START; mem1[8] = STOP3;
        esl[0] = 1; esl[1] = 1; esl[2] = 0; esl[4] = 1; esl[5] = 1; esl[6] = 0; esl[7] = 1;
        run_scan(10, 0);
        checks++; if (obs_tim != 0 || obs_oku != 10 || obs_bitti != 13) begin failures++;
            $display("FAIL two_timing errs=%0d reads=%0d bitti=%0d exp 0 10 13", obs_tim, obs_oku, obs_bitti); end
        checks++; if (protein_sayisi !== 8'd2 || en_iyi_puan !== 16'd3 || en_iyi_uzunluk !== 10'd4) begin failures++;
            $display("FAIL two_result got cnt=%0d puan=%0d uz=%0d exp 2 3 4", protein_sayisi, en_iyi_puan, en_iyi_uzunluk); end
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 1024; i++) begin mem1[i] = 6'd1; mem2[i] = 6'd0; esl[i] = 1; end
        mem1[0] = START;
        run_scan(1010, 0);
        checks++; if (obs_bitti != 1013 || protein_sayisi !== 8'd0 || en_iyi_puan !== 16'd0) begin failures++;
            $display("FAIL max_abort got bitti=%0d cnt=%0d puan=%0d exp 1013 0 0", obs_bitti, protein_sayisi, en_iyi_puan); end
        mem1[1000] = STOP1;
        run_scan(1010, 0);
        checks++; if (protein_sayisi !== 8'd1 || en_iyi_puan !== 16'd1000 || en_iyi_uzunluk !== 10'd1000) begin failures++;
            $display("FAIL max_stop got cnt=%0d puan=%0d uz=%0d exp 1 1000 1000", protein_sayisi, en_iyi_puan, en_iyi_uzunluk); end
    endtask

    task automatic test_zero_and_ignore();
        run_scan(0, 0);
        checks++; if (obs_bitti != 1 || obs_oku != 0 || obs_tim != 0) begin failures++;
            $display("FAIL zero_len got bitti=%0d reads=%0d errs=%0d exp 1 0 0", obs_bitti, obs_oku, obs_tim); end
        checks++; if (protein_sayisi !== 8'd0 || en_iyi_puan !== 16'd0) begin failures++;
            $display("FAIL zero_result got cnt=%0d puan=%0d exp 0 0", protein_sayisi, en_iyi_puan); end
        fill_random();
        model(6);
        run_scan(6, 1);
        checks++; if (obs_bitti != 9 || obs_oku != 6 || obs_tim != 0) begin failures++;
            $display("FAIL ignore_basla got bitti=%0d reads=%0d errs=%0d exp 9 6 0", obs_bitti, obs_oku, obs_tim); end
        checks++; if (protein_sayisi !== 8'(exp_sayi) || en_iyi_puan !== 16'(exp_puan) || en_iyi_uzunluk !== 10'(exp_uz)) begin failures++;
            $display("FAIL ignore_result got %0d %0d %0d exp %0d %0d %0d", protein_sayisi, en_iyi_puan, en_iyi_uzunluk, exp_sayi, exp_puan, exp_uz); end
    endtask

    task automatic test_tie_and_tail();
        fill_plain();
        mem1[0] = START; mem1[5] = STOP1; mem1[6] = START; mem1[12] = STOP2; mem1[13] = START;
        esl[0] = 1; esl[1] = 1; esl[2] = 1; esl[3] = 1; esl[4] = 0;
        esl[6] = 1; esl[7] = 1; esl[8] = 1; esl[9] = 1; esl[10] = 0; esl[11] = 0;
        esl[13] = 1; esl[14] = 1; esl[15] = 1;
        run_scan(16, 0);
        checks++; if (protein_sayisi !== 8'd2 || en_iyi_puan !== 16'd4 || en_iyi_uzunluk !== 10'd5) begin failures++;
            $display("FAIL tie_tail got cnt=%0d puan=%0d uz=%0d exp 2 4 5", protein_sayisi, en_iyi_puan, en_iyi_uzunluk); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        fill_random();
        @(negedge clk); basla = 1'b1; dizi_uzunluk = 11'd8;
        @(negedge clk); basla = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_oku !== 1'b1) begin failures++; $display("FAIL midrst_pre got oku=%b exp=1", mem_oku); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (mem_oku !== 1'b0 || mesgul !== 1'b0 || bitti !== 1'b0 || protein_sayisi !== 8'd0 || en_iyi_puan !== 16'd0) begin
            failures++; $display("FAIL midrst_state got oku=%b mesgul=%b bitti=%b cnt=%0d puan=%0d exp 0", mem_oku, mesgul, bitti, protein_sayisi, en_iyi_puan); end
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bitti === 1'b1 || mem_oku === 1'b1) seen = 1;
        end
        checks++; if (seen) begin failures++; $display("FAIL midrst_quiet got activity=1 exp=0"); end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 20; it++) begin
            fill_random();
            n = (it == 19) ? 1500 : int'($urandom_range(1, 80));
            model(n);
            run_scan(n, 0);
            checks++; if (obs_bitti != ((n > 1024) ? 1027 : n + 3) || obs_tim != 0 || obs_pres_err != 0) begin failures++;
                $display("FAIL rand_timing it=%0d n=%0d bitti=%0d errs=%0d pair_errs=%0d", it, n, obs_bitti, obs_tim, obs_pres_err); end
            checks++; if (protein_sayisi !== 8'(exp_sayi) || en_iyi_puan !== 16'(exp_puan) || en_iyi_uzunluk !== 10'(exp_uz)) begin failures++;
                $display("FAIL rand_result it=%0d got %0d %0d %0d exp %0d %0d %0d", it, protein_sayisi, en_iyi_puan, en_iyi_uzunluk, exp_sayi, exp_puan, exp_uz); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_two_proteins();
        test_max_len();
        test_zero_and_ignore();
        test_tie_and_tail();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
